regfile_wordline_sequencer: RTL and testbench

Parametrised, registered wordline generator for the register file. It decodes NUM_RD read addresses and one write address into one-hot wordlines. It flags write-to-read collisions so the datapath can bypass. It also runs a self-timed clear sweep that walks the write wordline across every register. It sits between the decode stage and the register array, replacing the fixed 4-to-16 read decoders with one block that serves all ports.

---
 rtl/regfile_wl_pkg.sv | 16 +
 rtl/onehot_decoder.sv | 22 ++
 rtl/regfile_wordline_sequencer.sv | 146 ++++++++++++++
 tb/tb_regfile_wordline_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wl_pkg.sv
// Shared types and sizing helpers for the register-file wordline sequencer.
package regfile_wl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } wl_state_e;

  localparam int MAX_RD = 4;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational id-to-wordline decoder; ids at or above NUM_REGS decode to zero.
module onehot_decoder #(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic [ADDR_W-1:0]   id,
  input  logic                en,
  output logic [NUM_REGS-1:0] wl,
  output logic                oor
);

  always_comb begin
    wl = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (en && (id == k[ADDR_W-1:0])) wl[k] = 1'b1;
    end
  end

  // An enabled id that lit nothing must have been out of range.
  assign oor = en & ~(|wl);

endmodule

// File: rtl/regfile_wordline_sequencer.sv
// Registered read/write wordline generator with write bypass flags and a
// self-timed clear sweep that walks the write wordline over every register.
//
// state | meaning
// IDLE  | normal decode, clr_req starts a sweep
// SWEEP | wr_wl walks one-hot(cnt), writes stalled
// DONE  | one-cycle clr_done pulse, writes stalled
module regfile_wordline_sequencer
  import regfile_wl_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_id,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [ADDR_W-1:0]          wr_id,
  input  logic                       wr_en,
  input  logic                       clr_req,
  output logic [NUM_RD*NUM_REGS-1:0] rd_wl,
  output logic [NUM_RD-1:0]          rd_err,
  output logic [NUM_REGS-1:0]        wr_wl,
  output logic                       clr_wr,
  output logic [NUM_RD-1:0]          bypass,
  output logic                       wr_stall,
  output logic                       clr_busy,
  output logic                       clr_done
);

  localparam int CNT_W = cnt_width(NUM_REGS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_REGS - 1);

  if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_bad_cfg
    $error("regfile_wordline_sequencer: NUM_RD out of range");
  end

  wl_state_e                        state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [NUM_RD*NUM_REGS-1:0]       rd_wl_q, rd_wl_d;
  logic [NUM_RD-1:0]                rd_err_q, rd_err_d;
  logic [NUM_REGS-1:0]              wr_wl_q, wr_wl_d;
  logic                             clr_wr_q, clr_wr_d;
  logic [NUM_RD-1:0]                bypass_q, bypass_d;
  logic                             clr_busy_q, clr_busy_d;
  logic                             clr_done_q, clr_done_d;

  logic [NUM_RD-1:0][NUM_REGS-1:0]  rd_dec_wl;
  logic [NUM_RD-1:0]                rd_dec_oor;
  logic [NUM_REGS-1:0]              wr_dec_wl;
  logic                             wr_dec_oor;
  logic                             wr_acc;

  assign wr_stall = (state_q != IDLE);
  assign wr_acc   = wr_en & ~wr_stall;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_dec
    onehot_decoder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd_dec (
      .id  (rd_id[p*ADDR_W +: ADDR_W]),
      .en  (rd_en[p]),
      .wl  (rd_dec_wl[p]),
      .oor (rd_dec_oor[p])
    );
  end

  onehot_decoder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_wr_dec (
    .id  (wr_id),
    .en  (wr_acc),
    .wl  (wr_dec_wl),
    .oor (wr_dec_oor)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_wl_q    <= '0;
      rd_err_q   <= '0;
      wr_wl_q    <= '0;
      clr_wr_q   <= 1'b0;
      bypass_q   <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_wl_q    <= rd_wl_d;
      rd_err_q   <= rd_err_d;
      wr_wl_q    <= wr_wl_d;
      clr_wr_q   <= clr_wr_d;
      bypass_q   <= bypass_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  // A sweep that started alongside an accepted write has not driven
  // register 0 yet (clr_wr_q low), so the counter holds for one step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (clr_wr_q) begin
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_wl_d    = rd_dec_wl;
    rd_err_d   = rd_dec_oor;
    bypass_d   = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      bypass_d[p] = rd_en[p] & (|wr_dec_wl) & (rd_id[p*ADDR_W +: ADDR_W] == wr_id);
    end
    wr_wl_d  = wr_dec_wl;
    clr_wr_d = 1'b0;
    if (state_d == SWEEP && !(state_q == IDLE && wr_acc)) begin
      wr_wl_d  = NUM_REGS'(1) << cnt_d;
      clr_wr_d = 1'b1;
    end
    clr_busy_d = (state_d != IDLE);
    clr_done_d = (state_d == DONE);
  end

  assign rd_wl    = rd_wl_q;
  assign rd_err   = rd_err_q;
  assign wr_wl    = wr_wl_q;
  assign clr_wr   = clr_wr_q;
  assign bypass   = bypass_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_wordline_sequencer.sv
// Bench for the wordline sequencer: a 16-register and a 12-register instance
// share stimulus and are checked each cycle against a sweep-plan model.
module tb_regfile_wordline_sequencer;

  localparam int AW  = 4;
  localparam int NRD = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NRD*AW-1:0] rd_id;
  logic [NRD-1:0]   rd_en;
  logic [AW-1:0]    wr_id;
  logic             wr_en;
  logic             clr_req;

  logic [31:0] a_rd_wl;
  logic [1:0]  a_rd_err, a_bypass;
  logic [15:0] a_wr_wl;
  logic        a_clr_wr, a_wr_stall, a_clr_busy, a_clr_done;

  logic [23:0] b_rd_wl;
  logic [1:0]  b_rd_err, b_bypass;
  logic [11:0] b_wr_wl;
  logic        b_clr_wr, b_wr_stall, b_clr_busy, b_clr_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wordline_sequencer #(.ADDR_W(AW), .NUM_REGS(16), .NUM_RD(NRD)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_id(rd_id), .rd_en(rd_en), .wr_id(wr_id),
    .wr_en(wr_en), .clr_req(clr_req), .rd_wl(a_rd_wl), .rd_err(a_rd_err),
    .wr_wl(a_wr_wl), .clr_wr(a_clr_wr), .bypass(a_bypass), .wr_stall(a_wr_stall),
    .clr_busy(a_clr_busy), .clr_done(a_clr_done)
  );

  regfile_wordline_sequencer #(.ADDR_W(AW), .NUM_REGS(12), .NUM_RD(NRD)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_id(rd_id), .rd_en(rd_en), .wr_id(wr_id),
    .wr_en(wr_en), .clr_req(clr_req), .rd_wl(b_rd_wl), .rd_err(b_rd_err),
    .wr_wl(b_wr_wl), .clr_wr(b_clr_wr), .bypass(b_bypass), .wr_stall(b_wr_stall),
    .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a pending sweep is a plan of register ids, then -1 (done pulse),
  // then -2 (return to idle). Writes are stalled while any plan item remains.
  int plan [2][0:19];
  int plen [2];
  int ppos [2];
  logic [31:0] e_rd_wl [2];
  logic [1:0]  e_rd_err [2], e_byp [2];
  logic [15:0] e_wr_wl [2];
  logic        e_clr_wr [2], e_busy [2], e_done [2];
  bit          chk_on = 0;

  task automatic model_step(input int i);
    int nr, id, it;
    bit acc;
    nr = (i == 0) ? 16 : 12;
    e_rd_wl[i] = '0; e_rd_err[i] = '0; e_byp[i] = '0;
    e_wr_wl[i] = '0; e_clr_wr[i] = 0; e_busy[i] = 0; e_done[i] = 0;
    if (!rst_n) begin
      plen[i] = 0; ppos[i] = 0;
      return;
    end
    acc = wr_en && (ppos[i] >= plen[i]);
    for (int p = 0; p < NRD; p++) begin
      id = int'(rd_id[p*AW +: AW]);
      if (rd_en[p] && id < nr) e_rd_wl[i] |= 32'd1 << (p*nr + id);
      if (rd_en[p] && id >= nr) e_rd_err[i][p] = 1'b1;
      if (rd_en[p] && acc && int'(wr_id) < nr && rd_id[p*AW +: AW] == wr_id) e_byp[i][p] = 1'b1;
    end
    it = -3;
    if (ppos[i] < plen[i]) begin
      it = plan[i][ppos[i]]; ppos[i]++;
    end else begin
      if (acc && int'(wr_id) < nr) e_wr_wl[i] = 16'd1 << wr_id;
      if (clr_req) begin
        for (int k = 0; k < nr; k++) plan[i][k] = k;
        plan[i][nr] = -1; plan[i][nr+1] = -2;
        plen[i] = nr + 2; ppos[i] = 0;
        e_busy[i] = 1;
        if (!acc) begin
          it = plan[i][0]; ppos[i] = 1;
        end
      end
    end
    if (it >= 0) begin
      e_wr_wl[i] = 16'd1 << it; e_clr_wr[i] = 1; e_busy[i] = 1;
    end else if (it == -1) begin
      e_done[i] = 1; e_busy[i] = 1;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) chk_on = 1;
    model_step(0);
    model_step(1);
    #1;
    if (chk_on) begin
      chk("a_rd_wl",  a_rd_wl, e_rd_wl[0]);
      chk("a_rd_err", 32'(a_rd_err), 32'(e_rd_err[0]));
      chk("a_bypass", 32'(a_bypass), 32'(e_byp[0]));
      chk("a_wr_wl",  32'(a_wr_wl), 32'(e_wr_wl[0]));
      chk("a_clr_wr", 32'(a_clr_wr), 32'(e_clr_wr[0]));
      chk("a_busy",   32'(a_clr_busy), 32'(e_busy[0]));
      chk("a_done",   32'(a_clr_done), 32'(e_done[0]));
      chk("a_stall",  32'(a_wr_stall), 32'(ppos[0] < plen[0]));
      chk("b_rd_wl",  32'(b_rd_wl), e_rd_wl[1]);
      chk("b_rd_err", 32'(b_rd_err), 32'(e_rd_err[1]));
      chk("b_bypass", 32'(b_bypass), 32'(e_byp[1]));
      chk("b_wr_wl",  32'(b_wr_wl), 32'(e_wr_wl[1]));
      chk("b_clr_wr", 32'(b_clr_wr), 32'(e_clr_wr[1]));
      chk("b_busy",   32'(b_clr_busy), 32'(e_busy[1]));
      chk("b_done",   32'(b_clr_done), 32'(e_done[1]));
      chk("b_stall",  32'(b_wr_stall), 32'(ppos[1] < plen[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((a_clr_busy || b_clr_busy) && n < 100) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(a_clr_busy | b_clr_busy), 32'd0);
  endtask

  initial begin
    int dcnt, icnt;
    rst_n = 0; rd_id = '0; rd_en = '0; wr_id = '0; wr_en = 0; clr_req = 0;
    tick(); tick();
    chk("rst_rd_wl", a_rd_wl, 32'd0);
    chk("rst_wr_wl", 32'(a_wr_wl), 32'd0);
    chk("rst_flags", {a_rd_err, a_bypass, a_clr_wr, a_clr_busy, a_clr_done}, 32'd0);
    rst_n = 1;

    rd_id = {4'd0, 4'd3}; rd_en = 2'b01;
    tick();
    chk("rd3_wl", 32'(a_rd_wl[15:0]), 32'h0008);
    chk("rd3_err", 32'(a_rd_err), 32'd0);

    rd_id = {4'd0, 4'd13}; rd_en = 2'b01; wr_id = 4'd14; wr_en = 1;
    tick();
    chk("b_oor_wl", 32'(b_rd_wl[11:0]), 32'd0);
    chk("b_oor_err", 32'(b_rd_err), 32'd1);
    chk("b_oor_wr", 32'(b_wr_wl), 32'd0);
    chk("b_oor_byp", 32'(b_bypass), 32'd0);
    chk("a_wr14", 32'(a_wr_wl), 32'h4000);

    wr_id = 4'd5; wr_en = 1; rd_id = {4'd5, 4'd5}; rd_en = 2'b01;
    tick();
    chk("col_byp", 32'(a_bypass), 32'd1);
    chk("col_wr", 32'(a_wr_wl), 32'h0020);
    chk("col_p1", 32'(a_rd_wl[31:16]), 32'd0);

    wr_en = 0; rd_en = 0; clr_req = 1;
    tick();
    chk("sw_wl0", 32'(a_wr_wl), 32'h0001);
    chk("sw_clr0", 32'(a_clr_wr), 32'd1);
    clr_req = 0; wr_en = 1; wr_id = 4'd6; rd_id = {4'd6, 4'd6}; rd_en = 2'b11;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("sw_wl", 32'(a_wr_wl), 32'(16'h0001 << k));
      chk("sw_stall", 32'(a_wr_stall), 32'd1);
      chk("sw_byp", 32'(a_bypass), 32'd0);
      chk("sw_nodone", 32'(a_clr_done), 32'd0);
    end
    chk("sw_rd", 32'(a_rd_wl[15:0]), 32'h0040);
    tick();
    chk("sw_done", 32'(a_clr_done), 32'd1);
    chk("sw_done_wl", 32'(a_wr_wl), 32'd0);
    tick();
    chk("sw_end", {a_clr_busy, a_clr_done}, 32'd0);
    wr_en = 0; rd_en = 0;
    wait_idle();

    wr_en = 1; wr_id = 4'd9; clr_req = 1;
    tick();
    chk("wc_wr", 32'(a_wr_wl), 32'h0200);
    chk("wc_busy", {a_clr_busy, a_clr_wr}, 32'h2);
    wr_en = 0; clr_req = 0;
    tick();
    chk("wc_wl0", 32'(a_wr_wl), 32'h0001);
    wait_idle();

    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (7) tick();
    chk("mr_step7", 32'(a_wr_wl), 32'h0080);
    rst_n = 0;
    tick();
    chk("mr_rst", {a_wr_wl, a_clr_busy, a_clr_done}, 32'd0);
    rst_n = 1;
    dcnt = 0;
    repeat (20) begin
      tick();
      dcnt += int'(a_clr_done);
    end
    chk("mr_nodone", 32'(dcnt), 32'd0);
    clr_req = 1;
    tick();
    clr_req = 0;
    chk("mr_restart", 32'(a_wr_wl), 32'h0001);
    wait_idle();

    dcnt = 0; icnt = 0; clr_req = 1;
    repeat (40) begin
      tick();
      dcnt += int'(a_clr_done);
      if (!a_clr_busy) icnt++;
    end
    clr_req = 0;
    chk("held_done", 32'(dcnt), 32'd2);
    chk("held_idle", 32'(icnt), 32'd2);
    wait_idle();

    repeat (3000) begin
      rd_id   = NRD*AW'($urandom);
      rd_en   = NRD'($urandom);
      wr_id   = AW'($urandom);
      wr_en   = 1'($urandom);
      clr_req = ($urandom_range(0, 29) == 0);
      rst_n   = ($urandom_range(0, 249) != 0);
      tick();
    end
    rst_n = 1; clr_req = 0; wr_en = 0;
    wait_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
